nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit. Processes one 4-bit nibble per clock, LSB first.
- Per cycle: generates P/G for the current nibble, resolves the four nibble carries with 4-bit lookahead logic, and registers the nibble's carry-out into the next cycle.
- Sits in the ALU datapath between the operand registers and the result/flag writeback.
- Valid/ready handshake on both the request side and the result side.

---
 rtl/alu_pkg.sv | 14 +
 rtl/pg_nibble_gen.sv | 16 +
 rtl/nibble_serial_adder.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the serial ALU datapath.
// Contents: adder_state_t (IDLE/RUN/DONE FSM encoding) and NIBBLE_W, the
// number of bits the serial adder resolves per clock.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

endpackage

// File: rtl/pg_nibble_gen.sv
// Propagate/generate terms for one nibble of the serial adder (purely combinational).
// Ports: a, b - operand nibble; p - per-bit propagate (a ^ b); g - per-bit generate (a & b).
// No state, no latency; feeds the lookahead carry logic in the top module.
module pg_nibble_gen
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] p,
  output logic [NIBBLE_W-1:0] g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per clock LSB first; result valid NIBBLES cycles after accept.
// Ports: clk, rst_n (async active-low); start_valid/start_ready + a, b, c_in, sub request side;
//        res_valid/res_ready + sum, c_out, overflow, zero result side. Optional flags via macro ALU_FLAGS_EN.
// Backpressure: request accepted only in IDLE; result held in DONE until res_ready, then one IDLE cycle.
module nibble_serial_adder #(
  parameter int WIDTH = 16  // must be a multiple of 4 and at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  import alu_pkg::*;

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  adder_state_t state, state_nxt;

  logic [WIDTH-1:0]    a_q, b_q, sum_q, sum_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                carry_q;
  logic                c_out_q;
  logic                accept, last;
  logic [NIBBLE_W-1:0] a_nib, b_nib, p, g, c;
  logic                nib_cout;

  // Operand B is stored already inverted for subtraction, so the nibble
  // datapath only ever adds.
  assign a_nib = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];

  pg_nibble_gen u_pg (
    .a (a_nib),
    .b (b_nib),
    .p (p),
    .g (g)
  );

  // Four-bit lookahead from the registered carry; c[3] is the carry into
  // the top bit of the nibble, needed later for signed overflow.
  always_comb begin
    c[0]     = carry_q;
    c[1]     = g[0] | (p[0] & carry_q);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
    nib_cout = g[3] | (p[3] & c[3]);
    sum_nxt  = sum_q;
    sum_nxt[int'(cnt)*NIBBLE_W +: NIBBLE_W] = p ^ c;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    accept      = 1'b0;
    last        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_NIB) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // start_ready stays low here, so a request arriving with the
        // consuming res_ready waits for the following IDLE cycle.
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, carry, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | c_in;  // subtraction always injects the +1
      cnt     <= '0;
      sum_q   <= '0;
    end else if (state == RUN) begin
      sum_q   <= sum_nxt;
      carry_q <= nib_cout;
      cnt     <= cnt + 1'b1;
      if (last) begin
        c_out_q <= nib_cout;
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

`ifdef ALU_FLAGS_EN
  logic ovf_q, zero_q;

  // Flags are captured from the final nibble on the DONE transition so they
  // stay aligned with the held sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (last) begin
      ovf_q  <= c[3] ^ nib_cout;
      zero_q <= (sum_nxt == '0);
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// An arithmetic model predicts every result and the handshake timing; directed
// vectors with literal expectations pin both the model and the DUT.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;
`ifdef ALU_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             sub = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .overflow    (overflow),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {signed_overflow, carry_out, sum}.
  function automatic logic [WIDTH+1:0] model_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;
    logic             v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s | ci)};
    v    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  // Transaction-level model: idle -> busy for NIBBLES cycles -> valid until consumed.
  logic             m_busy = 1'b0;
  logic             m_valid = 1'b0;
  int               m_cnt = 0;
  logic [WIDTH+1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      if (res_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == NIBBLES - 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end else if (start_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_res  <= model_op(a, b, c_in, sub);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk1("model res_valid", res_valid, m_valid);
      chk1("model start_ready", start_ready, !(m_busy || m_valid));
      if (m_valid) begin
        chkw("model sum", sum, m_res[WIDTH-1:0]);
        chk1("model c_out", c_out, m_res[WIDTH]);
        chk1("model overflow", overflow, FLAGS & m_res[WIDTH+1]);
        chk1("model zero", zero, FLAGS & (m_res[WIDTH-1:0] == '0));
      end
    end
  end

  // One full operation with literal expectations and latency check.
  task automatic do_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tci, input logic ts, input logic [WIDTH-1:0] esum,
                       input logic ecout, input logic eovf, input logic ezero);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tci; sub = ts; start_valid = 1'b1;
    chk1({name, " start_ready"}, start_ready, 1'b1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    // operands are registered; scramble the inputs to prove it
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = ~tci; sub = ~ts;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chki({name, " latency"}, lat, NIBBLES);
    chkw({name, " sum"}, sum, esum);
    chk1({name, " c_out"}, c_out, ecout);
    chk1({name, " overflow"}, overflow, FLAGS & eovf);
    chk1({name, " zero"}, zero, FLAGS & ezero);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk1({name, " released"}, res_valid, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk1("reset res_valid", res_valid, 1'b0);
    chk1("reset start_ready", start_ready, 1'b1);
    chkw("reset sum", sum, '0);
    chk1("reset c_out", c_out, 1'b0);
    chk1("reset overflow", overflow, 1'b0);
    chk1("reset zero", zero, 1'b0);
    #9 rst_n = 1'b1;

    do_op("add basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_op("add wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("sub neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op("add ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("add cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    do_op("sub eq",    16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held while res_ready low, new request waits.
    begin
      int lat;
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chki("hold latency", lat, NIBBLES);
      a = 16'h0100; b = 16'h0001; sub = 1'b1; start_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk1("hold res_valid", res_valid, 1'b1);
        chk1("hold start_ready", start_ready, 1'b0);
        chkw("hold sum", sum, 16'h3333);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk1("after pulse start_ready", start_ready, 1'b1);
      chk1("after pulse res_valid", res_valid, 1'b0);
      @(posedge clk); #1;
      chk1("queued accepted", start_ready, 1'b0);
      start_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chki("queued latency", lat, NIBBLES);
      chkw("queued sum", sum, 16'h00FF);
      chk1("queued c_out", c_out, 1'b1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end

    // Asynchronous reset while nibble 2 is in flight.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("midrun rst res_valid", res_valid, 1'b0);
    chkw("midrun rst sum", sum, '0);
    chk1("midrun rst start_ready", start_ready, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(posedge clk); #1;
      chk1("no result after rst", res_valid, 1'b0);
    end
    do_op("post rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
